// File: rtl/pkt_buf_reader.sv
// pkt_buf_reader
//   Turns (address, length) read requests into reads on a synchronous
//   buffer port with one cycle of read latency. The returned words go
//   through a 4-entry FIFO and out as a valid/ready word stream. The
//   final word of each request is tagged with out_last.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | req_ready high; waiting for a request
//   READ  | issuing buffer reads for the accepted request, credit-limited
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/ready/addr/len  request handshake: start word address and word count
//   mem_en/we/addr/rdata      buffer read port (rdata valid 1 cycle after mem_en)
//   out_valid/ready/data/last output word stream
//   busy                      a request is issuing, a read is in flight, or data is buffered

module pkt_buf_reader #(
    parameter int AW = 11,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_len,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic {IDLE, READ} state_t;

    state_t        state;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_rem;

    logic [DW-1:0] fifo_data [4];
    logic [3:0]    fifo_last;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic          inflight;
    logic          inflight_last;

    logic accept;
    logic issue;
    logic push;
    logic pop;

    assign accept = req_valid && req_ready;
    // A read may go out only when its word is sure to find room in the FIFO.
    // The in-flight word already holds a slot, so it counts against the credit.
    assign issue  = (state == READ) && ((count + {2'b00, inflight}) < 3'd4);
    assign push   = inflight;
    assign pop    = out_valid && out_ready;

    assign req_ready = (state == IDLE) && !rst;
    assign mem_en    = issue;
    assign mem_we    = 1'b0;
    assign mem_addr  = rd_addr;
    assign out_valid = (count != 3'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign busy      = (state == READ) || inflight || (count != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_rem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (req_len != 8'd0)) begin
                        rd_addr <= req_addr;
                        rd_rem  <= req_len;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + AW'(1);
                        rd_rem  <= rd_rem - 8'd1;
                        if (rd_rem == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_last     <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_rem == 8'd1);
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_buf_reader.sv
module tb_pkt_buf_reader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [10:0]  req_addr = '0;
    logic [7:0]   req_len = '0;
    logic         mem_en;
    logic         mem_we;
    logic [10:0]  mem_addr;
    logic [127:0] mem_rdata = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    pkt_buf_reader #(.AW(11), .DW(128)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word_of(input logic [10:0] a);
        return {21'h1A5A5A, a, 21'h0C3C3, a, 32'hDEAD_0000 | 32'(a), 32'(a) ^ 32'h5555_AAAA};
    endfunction

    // Buffer model: one cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= word_of(mem_addr);
    end

    task automatic check_all_zero(input string tag);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s_req_ready: got %0b want 0", tag, req_ready); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL %s_mem_en: got %0b want 0", tag, mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s_mem_we: got %0b want 0", tag, mem_we); end
        checks++; if (mem_addr !== 11'h000) begin errors++; $display("FAIL %s_mem_addr: got %h want 000", tag, mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid: got %0b want 0", tag, out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL %s_out_data: got %h want 0", tag, out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL %s_out_last: got %0b want 0", tag, out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %0b want 0", tag, busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_basic();
        logic exp_ov;
        @(negedge clk);
        out_ready = 1'b1;
        req_valid = 1'b1; req_addr = 11'h010; req_len = 8'd4;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++; if (mem_en !== (i < 4)) begin errors++; $display("FAIL basic_mem_en c%0d: got %0b want %0b", i, mem_en, (i < 4)); end
            if (i < 4) begin
                checks++; if (mem_addr !== 11'(16 + i)) begin errors++; $display("FAIL basic_mem_addr c%0d: got %h want %h", i, mem_addr, 11'(16 + i)); end
            end
            exp_ov = (i >= 2) && (i < 6);
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL basic_out_valid c%0d: got %0b want %0b", i, out_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if (out_data !== word_of(11'(16 + i - 2))) begin errors++; $display("FAIL basic_out_data c%0d: got %h want %h", i, out_data, word_of(11'(16 + i - 2))); end
                checks++; if (out_last !== (i == 5)) begin errors++; $display("FAIL basic_out_last c%0d: got %0b want %0b", i, out_last, (i == 5)); end
            end
            checks++; if (busy !== (i < 6)) begin errors++; $display("FAIL basic_busy c%0d: got %0b want %0b", i, busy, (i < 6)); end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic exp_ov;
        out_ready = 1'b1;
        req_valid = 1'b1; req_addr = 11'h7FE; req_len = 8'd3;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (mem_en !== (i < 3)) begin errors++; $display("FAIL wrap_mem_en c%0d: got %0b want %0b", i, mem_en, (i < 3)); end
            if (i < 3) begin
                checks++; if (mem_addr !== 11'(12'h7FE + i)) begin errors++; $display("FAIL wrap_mem_addr c%0d: got %h want %h", i, mem_addr, 11'(12'h7FE + i)); end
            end
            exp_ov = (i >= 2) && (i < 5);
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL wrap_out_valid c%0d: got %0b want %0b", i, out_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if (out_data !== word_of(11'(12'h7FE + i - 2))) begin errors++; $display("FAIL wrap_out_data c%0d: got %h want %h", i, out_data, word_of(11'(12'h7FE + i - 2))); end
                checks++; if (out_last !== (i == 4)) begin errors++; $display("FAIL wrap_out_last c%0d: got %0b want %0b", i, out_last, (i == 4)); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_valid = 1'b1; req_addr = 11'h300; req_len = 8'd8;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++; if (mem_en !== (i < 4)) begin errors++; $display("FAIL bp_mem_en c%0d: got %0b want %0b", i, mem_en, (i < 4)); end
            if (i < 4) begin
                checks++; if (mem_addr !== 11'(12'h300 + i)) begin errors++; $display("FAIL bp_mem_addr c%0d: got %h want %h", i, mem_addr, 11'(12'h300 + i)); end
            end
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c%0d: got %0b want 1", i, out_valid); end
                checks++; if (out_data !== word_of(11'h300)) begin errors++; $display("FAIL bp_hold_data c%0d: got %h want %h", i, out_data, word_of(11'h300)); end
            end
            @(negedge clk);
        end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL bp_stalled_mem_en: got %0b want 0", mem_en); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid w%0d: got %0b want 1", k, out_valid); end
            checks++; if (out_data !== word_of(11'(12'h300 + k))) begin errors++; $display("FAIL bp_drain_data w%0d: got %h want %h", k, out_data, word_of(11'(12'h300 + k))); end
            checks++; if (out_last !== (k == 7)) begin errors++; $display("FAIL bp_drain_last w%0d: got %0b want %0b", k, out_last, (k == 7)); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %0b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_end: got %0b want 0", out_valid); end
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        req_valid = 1'b1; req_addr = 11'h123; req_len = 8'd0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_pre: got %0b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL zero_mem_en c%0d: got %0b want 0", i, mem_en); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid c%0d: got %0b want 0", i, out_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_req_ready c%0d: got %0b want 1", i, req_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy c%0d: got %0b want 0", i, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] got_d[$];
        logic         got_l[$];
        logic [10:0]  exp_a [3] = '{11'h100, 11'h101, 11'h200};
        logic         exp_l [3] = '{1'b0, 1'b1, 1'b1};
        logic         acc_pending;
        int           sent = 0;
        out_ready = 1'b1;
        req_valid = 1'b1; req_addr = 11'h100; req_len = 8'd2;
        acc_pending = req_ready;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid) begin got_d.push_back(out_data); got_l.push_back(out_last); end
            if (acc_pending) begin
                sent++;
                if (sent < 2) begin req_addr = 11'h200; req_len = 8'd1; end
                else req_valid = 1'b0;
            end
            acc_pending = req_valid && req_ready;
        end
        req_valid = 1'b0;
        checks++; if (sent !== 2) begin errors++; $display("FAIL b2b_accepted: got %0d want 2", sent); end
        checks++; if (got_d.size() !== 3) begin errors++; $display("FAIL b2b_word_count: got %0d want 3", got_d.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got_d.size()) begin
                checks++; if (got_d[k] !== word_of(exp_a[k])) begin errors++; $display("FAIL b2b_data w%0d: got %h want %h", k, got_d[k], word_of(exp_a[k])); end
                checks++; if (got_l[k] !== exp_l[k]) begin errors++; $display("FAIL b2b_last w%0d: got %0b want %0b", k, got_l[k], exp_l[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got_d[$];
        logic         got_l[$];
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 11'h400; req_len = 8'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_active: got %0b want 1", out_valid); end
        rst = 1'b1;
        #1;
        check_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %0b want 1", req_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_residual_en c%0d: got %0b want 0", i, mem_en); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_residual_valid c%0d: got %0b want 0", i, out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_residual_busy c%0d: got %0b want 0", i, busy); end
        end
        req_valid = 1'b1; req_addr = 11'h500; req_len = 8'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin got_d.push_back(out_data); got_l.push_back(out_last); end
            @(negedge clk);
        end
        checks++; if (got_d.size() !== 2) begin errors++; $display("FAIL rstmid_fresh_count: got %0d want 2", got_d.size()); end
        for (int k = 0; k < 2; k++) begin
            if (k < got_d.size()) begin
                checks++; if (got_d[k] !== word_of(11'(12'h500 + k))) begin errors++; $display("FAIL rstmid_fresh_data w%0d: got %h want %h", k, got_d[k], word_of(11'(12'h500 + k))); end
                checks++; if (got_l[k] !== (k == 1)) begin errors++; $display("FAIL rstmid_fresh_last w%0d: got %0b want %0b", k, got_l[k], (k == 1)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
